palette_lookup_arbiter: RTL and testbench
=========================================

Name: palette_lookup_arbiter

Overview:
- Shared palette store for all sprite render pipelines: NUM_PAL palettes × 16 entries × 24-bit RGB. Examples are player1, player2, background and UI palettes.
- Round-robin arbitration between NUM_REQ render requesters for one lookup per cycle. Registered response, 1-cycle latency.
- Host/loader write port updates palette entries at runtime. Used for palette swaps and hit-flash effects.
- Index 0 of every palette is transparent by definition.

Parameters:
- NUM_REQ, 4, number of render requesters (2..8).
- NUM_PAL, 4, number of palettes (power of 2).
- PAL_W, 2, palette-id width, equal to log2(NUM_PAL).
- COLOR_W, 24, RGB width.
- WR_MAX_BLOCK, 4, maximum consecutive write cycles allowed while reads are pending.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester lookup request.
- i_req_pal  in  NUM_REQ*PAL_W  palette id; requester k uses bits [k*PAL_W +: PAL_W].
- i_req_idx  in  NUM_REQ*4  color index; requester k uses bits [k*4 +: 4].
- o_req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- o_rsp_valid  out  NUM_REQ  one-hot, asserted the cycle after the grant.
- o_rsp_color  out  COLOR_W  looked-up color, valid with o_rsp_valid.
- o_rsp_transparent  out  1  high when the looked-up index was 0.
- i_wr_en  in  1  palette write request.
- i_wr_pal  in  PAL_W  palette id to write.
- i_wr_idx  in  4  entry index to write.
- i_wr_color  in  COLOR_W  color value to write.
- o_wr_ready  out  1  write accepted when i_wr_en && o_wr_ready.

Behaviour:
- Storage:
  - NUM_PAL*16 words of COLOR_W, addressed as {pal, idx}.
  - Not cleared by reset; contents are undefined until written.
  - Index-0 entries may be written, but lookups of idx 0 never return them.
- Reset values:
  - o_req_ready=0, o_rsp_valid=0, o_rsp_color=0, o_rsp_transparent=0.
  - RR pointer=0, block counter=0, o_wr_ready=1.
  - Reset asserted mid-operation drops any in-flight response: o_rsp_valid=0 on the next edge.
- Port cycle modes:
  - WRITE: i_wr_en=1 and block counter < WR_MAX_BLOCK.
    - o_wr_ready=1; the write commits at the clock edge.
    - o_req_ready=0 for all requesters.
  - READ: otherwise.
    - o_wr_ready=0 if i_wr_en=1 (the write is stalled, and the writer must hold its inputs).
    - Arbitration grants at most one requester.
- Block counter:
  - Increments in a WRITE cycle while any i_req_valid=1 (saturating).
  - Clears in any cycle where a grant occurs, or where no request is pending.
  - Effect: reads get at least 1 cycle in every WR_MAX_BLOCK+1 under continuous writes.
- Arbitration:
  - Grant the first k with i_req_valid[k]=1, searching cyclically from the RR pointer.
  - On a grant, pointer := (k+1) mod NUM_REQ. With no grant the pointer holds.
  - o_req_ready is combinational from i_req_valid, the pointer and the mode. It is never asserted for a non-valid requester.
- Response (registered, latency 1):
  - Cycle after a grant: o_rsp_valid[k]=1 and o_rsp_color = mem[{pal,idx}].
  - If idx==0: o_rsp_color=0 and o_rsp_transparent=1.
  - Otherwise o_rsp_transparent=0.
  - With no grant, o_rsp_valid=0 and color/transparent hold their previous values.
- Write/read ordering:
  - Reads and writes never occur in the same cycle.
  - A read granted the cycle after a write to the same address returns the new value.
- Request inputs are sampled only in the grant cycle. The requester may change them after the grant.
- Back-to-back grants to different requesters on consecutive cycles are allowed, giving full throughput of 1 lookup per cycle.
- Out-of-range palette id is impossible, since NUM_PAL is a power of 2.

Test Plan:
1. Reset, then write pal1 idx3=24'h7fff7f and pal1 idx15=24'h416f2c (o_wr_ready=1 each cycle). Then req0 looks up (1,3) -> grant same cycle; next cycle o_rsp_valid=4'b0001, color 24'h7fff7f, transparent=0.
2. Write pal2 idx0=24'hfefe00, then req1 looks up (2,0) -> o_rsp_color=0, o_rsp_transparent=1.
3. All 4 requesters valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; o_rsp_valid follows 1 cycle later; exactly one grant per cycle.
4. i_wr_en held high for 10 cycles while req2 is valid -> writes accepted for 4 cycles, then o_wr_ready=0 and req2 granted on cycle 5, then writes resume. Verify written values by later reads.
5. Write pal0 idx5=24'h00fe00, then req3 requests (0,5) in the very next cycle -> response color 24'h00fe00.
6. Assert i_rst in the cycle after a grant -> o_rsp_valid=0 and o_rsp_color=0. Next request after reset is granted to the lowest valid requester (pointer=0).

Source files
------------

// File: rtl/palette_lookup_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | palette_lookup_arbiter                                                     |
// | Shared palette RAM with a round-robin lookup port and a host write port.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module palette_lookup_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_PAL      = 4,
  parameter int PAL_W        = 2,
  parameter int COLOR_W      = 24,
  parameter int WR_MAX_BLOCK = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*PAL_W-1:0] i_req_pal,
  input  logic [NUM_REQ*4-1:0]     i_req_idx,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [COLOR_W-1:0]       o_rsp_color,
  output logic                     o_rsp_transparent,
  input  logic                     i_wr_en,
  input  logic [PAL_W-1:0]         i_wr_pal,
  input  logic [3:0]               i_wr_idx,
  input  logic [COLOR_W-1:0]       i_wr_color,
  output logic                     o_wr_ready
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_BLK_W = $clog2(WR_MAX_BLOCK + 1);
  localparam int c_DEPTH = NUM_PAL * 16;

  logic [COLOR_W-1:0] r_mem [c_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_BLK_W-1:0] r_blk;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [COLOR_W-1:0] r_rsp_color;
  logic               r_rsp_transparent;

  logic               w_blk_ok;
  logic               w_write_mode;
  logic               w_any_req;
  logic               w_gnt_any;
  logic [c_PTR_W-1:0] w_gnt_idx;
  logic [c_PTR_W-1:0] w_ptr_next;
  logic [NUM_REQ-1:0] w_grant;
  logic [PAL_W-1:0]   w_rd_pal;
  logic [3:0]         w_rd_idx;

  assign w_blk_ok     = (r_blk < c_BLK_W'(WR_MAX_BLOCK));
  assign w_write_mode = i_wr_en && w_blk_ok && !i_rst;
  assign w_any_req    = |i_req_valid;

  // Cyclic search starting at the round-robin pointer; suppressed in write cycles.
  always_comb begin
    int k;
    k         = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    if (!w_write_mode && !i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = int'(r_ptr) + i;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        if (!w_gnt_any && i_req_valid[k]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = c_PTR_W'(k);
        end
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_next = (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_rd_pal   = i_req_pal[w_gnt_idx*PAL_W +: PAL_W];
  assign w_rd_idx   = i_req_idx[w_gnt_idx*4 +: 4];

  // Palette contents survive reset; only the host port writes them.
  always_ff @(posedge i_clk) begin
    if (w_write_mode) r_mem[{i_wr_pal, i_wr_idx}] <= i_wr_color;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr             <= '0;
      r_blk             <= '0;
      r_rsp_valid       <= '0;
      r_rsp_color       <= '0;
      r_rsp_transparent <= 1'b0;
    end else begin
      r_rsp_valid <= w_grant;
      if (w_gnt_any) begin
        r_ptr <= w_ptr_next;
        if (w_rd_idx == 4'd0) begin
          r_rsp_color       <= '0;
          r_rsp_transparent <= 1'b1;
        end else begin
          r_rsp_color       <= r_mem[{w_rd_pal, w_rd_idx}];
          r_rsp_transparent <= 1'b0;
        end
      end
      // Guarantees readers a slot at least once every WR_MAX_BLOCK+1 cycles.
      if (w_gnt_any || !w_any_req) begin
        r_blk <= '0;
      end else if (w_write_mode && w_blk_ok) begin
        r_blk <= r_blk + 1'b1;
      end
    end
  end

  assign o_req_ready       = w_grant;
  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_color       = r_rsp_color;
  assign o_rsp_transparent = r_rsp_transparent;
  assign o_wr_ready        = w_blk_ok;

endmodule
`default_nettype wire

// File: tb/tb_palette_lookup_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_palette_lookup_arbiter                                                  |
// | Directed self-checking bench for palette_lookup_arbiter.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_palette_lookup_arbiter;

  localparam int c_NUM_REQ = 4;
  localparam int c_PAL_W   = 2;
  localparam int c_COLOR_W = 24;

  logic                         r_clk = 1'b0;
  logic                         r_rst;
  logic [c_NUM_REQ-1:0]         r_req_valid;
  logic [c_NUM_REQ*c_PAL_W-1:0] r_req_pal;
  logic [c_NUM_REQ*4-1:0]       r_req_idx;
  logic [c_NUM_REQ-1:0]         w_req_ready;
  logic [c_NUM_REQ-1:0]         w_rsp_valid;
  logic [c_COLOR_W-1:0]         w_rsp_color;
  logic                         w_rsp_transparent;
  logic                         r_wr_en;
  logic [c_PAL_W-1:0]           r_wr_pal;
  logic [3:0]                   r_wr_idx;
  logic [c_COLOR_W-1:0]         r_wr_color;
  logic                         w_wr_ready;

  int r_total = 0;
  int r_bad   = 0;

  always #5 r_clk = ~r_clk;

  palette_lookup_arbiter #(
    .NUM_REQ(4), .NUM_PAL(4), .PAL_W(2), .COLOR_W(24), .WR_MAX_BLOCK(4)
  ) u_dut (
    .i_clk            (r_clk),
    .i_rst            (r_rst),
    .i_req_valid      (r_req_valid),
    .i_req_pal        (r_req_pal),
    .i_req_idx        (r_req_idx),
    .o_req_ready      (w_req_ready),
    .o_rsp_valid      (w_rsp_valid),
    .o_rsp_color      (w_rsp_color),
    .o_rsp_transparent(w_rsp_transparent),
    .i_wr_en          (r_wr_en),
    .i_wr_pal         (r_wr_pal),
    .i_wr_idx         (r_wr_idx),
    .i_wr_color       (r_wr_color),
    .o_wr_ready       (w_wr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_total++;
    if (obs !== exp) begin
      r_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic set_req(input int k, input int pal, input int idx);
    r_req_valid[k]              = 1'b1;
    r_req_pal[k*c_PAL_W +: c_PAL_W] = c_PAL_W'(pal);
    r_req_idx[k*4 +: 4]         = 4'(idx);
  endtask

  task automatic do_write(input int pal, input int idx, input logic [23:0] color);
    r_wr_en    = 1'b1;
    r_wr_pal   = c_PAL_W'(pal);
    r_wr_idx   = 4'(idx);
    r_wr_color = color;
    #1;
    chk("wr_ready", 32'(w_wr_ready), 32'd1);
    chk("wr_blocks_req", 32'(w_req_ready), 32'd0);
    tick();
    r_wr_en = 1'b0;
  endtask

  task automatic lookup(input int k, input int pal, input int idx,
                        input logic [23:0] exp_color, input logic exp_tr);
    set_req(k, pal, idx);
    #1;
    chk("req_ready", 32'(w_req_ready), 32'd1 << k);
    tick();
    r_req_valid = '0;
    chk("rsp_valid", 32'(w_rsp_valid), 32'd1 << k);
    chk("rsp_color", 32'(w_rsp_color), 32'(exp_color));
    chk("rsp_transparent", 32'(w_rsp_transparent), 32'(exp_tr));
  endtask

  initial begin
    int n;
    logic exp_wr;
    r_rst = 1'b1; r_req_valid = '0; r_req_pal = '0; r_req_idx = '0;
    r_wr_en = 1'b0; r_wr_pal = '0; r_wr_idx = '0; r_wr_color = '0;
    tick(); tick();
    chk("rst_req_ready", 32'(w_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(w_rsp_valid), 32'd0);
    chk("rst_rsp_color", 32'(w_rsp_color), 32'd0);
    chk("rst_rsp_tr", 32'(w_rsp_transparent), 32'd0);
    chk("rst_wr_ready", 32'(w_wr_ready), 32'd1);
    r_rst = 1'b0;

    // Basic write then lookup, plus hold of color when idle
    do_write(1, 3, 24'h7fff7f);
    do_write(1, 15, 24'h416f2c);
    lookup(0, 1, 3, 24'h7fff7f, 1'b0);
    tick();
    chk("idle_rsp_valid", 32'(w_rsp_valid), 32'd0);
    chk("idle_color_hold", 32'(w_rsp_color), 32'h7fff7f);

    // Index 0 is transparent regardless of stored value
    do_write(2, 0, 24'hfefe00);
    lookup(1, 2, 0, 24'h000000, 1'b1);

    // Read directly after write returns the new value
    do_write(0, 5, 24'h00fe00);
    lookup(3, 0, 5, 24'h00fe00, 1'b0);

    // Write blocking: 4 writes, forced read, 4 writes, forced read
    set_req(2, 1, 15);
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      r_wr_en    = 1'b1;
      r_wr_pal   = 2'd3;
      r_wr_idx   = 4'(8 + n);
      r_wr_color = 24'ha0b0c0 + 24'(n);
      exp_wr     = (c != 5) && (c != 10);
      #1;
      chk("blk_wr_ready", 32'(w_wr_ready), 32'(exp_wr));
      chk("blk_req_ready", 32'(w_req_ready), exp_wr ? 32'd0 : 32'b0100);
      tick();
      chk("blk_rsp_valid", 32'(w_rsp_valid), exp_wr ? 32'd0 : 32'b0100);
      if (!exp_wr) chk("blk_rsp_color", 32'(w_rsp_color), 32'h416f2c);
      if (exp_wr) n++;
    end
    r_wr_en = 1'b0;
    r_req_valid = '0;
    chk("blk_write_count", 32'(n), 32'd8);
    lookup(0, 3, 8, 24'ha0b0c0, 1'b0);
    lookup(1, 3, 12, 24'ha0b0c4, 1'b0);
    lookup(2, 3, 15, 24'ha0b0c7, 1'b0);

    // Round-robin from a fresh reset with all requesters active
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    for (int k = 0; k < c_NUM_REQ; k++) set_req(k, 1, 3);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_ready", 32'(w_req_ready), 32'd1 << (c % 4));
      tick();
      chk("rr_rsp_valid", 32'(w_rsp_valid), 32'd1 << (c % 4));
      chk("rr_rsp_color", 32'(w_rsp_color), 32'h7fff7f);
    end
    r_req_valid = '0;
    tick();

    // Reset right after a grant drops the response and rewinds the pointer
    set_req(2, 1, 3);
    tick();
    r_req_valid = '0;
    chk("pre_rst_rsp_valid", 32'(w_rsp_valid), 32'b0100);
    r_rst = 1'b1;
    set_req(0, 1, 3);
    set_req(3, 1, 3);
    #1;
    chk("in_rst_req_ready", 32'(w_req_ready), 32'd0);
    tick();
    chk("post_rst_rsp_valid", 32'(w_rsp_valid), 32'd0);
    chk("post_rst_rsp_color", 32'(w_rsp_color), 32'd0);
    r_rst = 1'b0;
    #1;
    chk("post_rst_ptr", 32'(w_req_ready), 32'b0001);
    tick();
    chk("post_rst_grant_rsp", 32'(w_rsp_valid), 32'b0001);
    r_req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", r_total, r_bad);
    $finish;
  end

endmodule
`default_nettype wire
